// File: rtl/pe_row_feeder.sv
// West-edge X source for one row of the systolic MAC array: loads COLS weights,
// latches them once the row is quiet, then streams a counted burst of activations.
module pe_row_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_load_w,
    input  logic [CNT_WIDTH-1:0]  cfg_num_act,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  row_busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_weight_shift,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  weight_latch_en
);

    localparam int WCW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WAIT_W,
        S_LATCH,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state;
    logic [WCW-1:0]       w_cnt;
    logic [CNT_WIDTH-1:0] act_left;
    logic                 load_en;
    logic                 s_hs;

    // Handshake: a token moves on s when s_valid && s_ready and on m when
    // m_valid && m_ready; once valid is raised, data holds until accepted.
    assign load_en = !m_valid || m_ready;
    assign s_ready = load_en &&
                     ((state == S_LOAD_W) ||
                      ((state == S_STREAM) && (act_left != '0)));
    assign s_hs    = s_valid && s_ready;

    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);
    assign weight_latch_en = (state == S_LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            w_cnt    <= '0;
            act_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        act_left <= cfg_num_act;
                        w_cnt    <= '0;
                        if (cfg_load_w)
                            state <= S_LOAD_W;
                        else if (cfg_num_act == '0)
                            state <= S_FLUSH;
                        else
                            state <= S_STREAM;
                    end
                end
                S_LOAD_W: begin
                    if (s_hs) begin
                        if (w_cnt == WCW'(COLS - 1)) begin
                            w_cnt <= '0;
                            state <= S_WAIT_W;
                        end else begin
                            w_cnt <= w_cnt + WCW'(1);
                        end
                    end
                end
                // Shadow regs may only be latched after every weight has left the
                // output stage and finished shifting through the row.
                S_WAIT_W: begin
                    if (!m_valid && !row_busy)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    state <= (act_left == '0) ? S_FLUSH : S_STREAM;
                end
                S_STREAM: begin
                    if (s_hs) begin
                        act_left <= act_left - CNT_WIDTH'(1);
                        if (act_left == CNT_WIDTH'(1))
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!m_valid)
                        state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid        <= 1'b0;
            m_weight_shift <= 1'b0;
            m_data         <= '0;
        end else if (s_hs) begin
            m_valid        <= 1'b1;
            m_weight_shift <= (state == S_LOAD_W);
            m_data         <= s_data;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Bench for pe_row_feeder: randomized upstream/downstream timing checked against
// an in-order token queue plus job-level expectations (latch, done, accept count).
module tb_pe_row_feeder;

    localparam int DW   = 8;
    localparam int COLS = 4;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_load_w;
    logic [CW-1:0] cfg_num_act;
    logic          busy;
    logic          done;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          row_busy;
    logic          m_valid;
    logic          m_ready;
    logic          m_weight_shift;
    logic [DW-1:0] m_data;
    logic          weight_latch_en;

    pe_row_feeder #(.DATA_WIDTH(DW), .COLS(COLS), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_load_w     (cfg_load_w),
        .cfg_num_act    (cfg_num_act),
        .busy           (busy),
        .done           (done),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .row_busy       (row_busy),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_weight_shift (m_weight_shift),
        .m_data         (m_data),
        .weight_latch_en(weight_latch_en)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] src_q[$];
    logic [DW:0]   exp_q[$];

    bit job_active = 1'b0;
    bit job_lw;
    int job_num_act;
    int job_total;
    int acc_cnt;
    int latch_cnt;
    int done_cnt;
    int done_cyc;
    int start_cyc;
    int last_w_cyc;
    int mr_mode = 0;
    bit rb_mode = 1'b0;
    int busy_hold = 0;
    bit src_hs;
    logic [DW:0] e_tok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // upstream source: random gaps, valid held until accepted
    always begin
        @(negedge clk);
        src_hs = s_valid && s_ready && rst_n;
        @(posedge clk);
        #1;
        if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
        if (!(s_valid && !src_hs)) begin
            if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
            end
        end
    end

    // downstream ready: 0 = always, 1 = toggle 1010, 2 = random
    always begin
        @(posedge clk);
        #1;
        case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // row_busy: held high for a while after the weights leave, when requested
    always begin
        @(posedge clk);
        #1;
        if (busy_hold > 0) begin
            row_busy = 1'b1;
            busy_hold--;
        end else begin
            row_busy = 1'b0;
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (job_active && acc_cnt == job_total) check("s_ready_quiet", s_ready, 0);
            if (s_valid && s_ready) acc_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_token", 1, 0);
                end else begin
                    e_tok = exp_q.pop_front();
                    check("tok_data", m_data, e_tok[DW-1:0]);
                    check("tok_shift", m_weight_shift, e_tok[DW]);
                    if (e_tok[DW] && (exp_q.size() == 0 || !exp_q[0][DW])) begin
                        last_w_cyc = cyc;
                        if (rb_mode) busy_hold = 5;
                    end
                end
            end
            if (weight_latch_en) begin
                latch_cnt++;
                check("latch_before_act", exp_q.size(), job_num_act);
                check("latch_gap", cyc - last_w_cyc, rb_mode ? 7 : 2);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_drained", exp_q.size(), 0);
            end
        end
    end

    task automatic start_job(input bit lw, input int n, input int mrm, input bit rbm, input bit directed);
        logic [DW-1:0] v;
        src_q.delete();
        exp_q.delete();
        if (lw) begin
            for (int i = 0; i < COLS; i++) begin
                v = directed ? DW'(i + 1) : DW'($urandom);
                src_q.push_back(v);
                exp_q.push_back({1'b1, v});
            end
        end
        for (int i = 0; i < n; i++) begin
            v = directed ? DW'(10 + i) : DW'($urandom);
            src_q.push_back(v);
            exp_q.push_back({1'b0, v});
        end
        job_lw      = lw;
        job_num_act = n;
        job_total   = (lw ? COLS : 0) + n;
        acc_cnt     = 0;
        latch_cnt   = 0;
        done_cnt    = 0;
        mr_mode     = mrm;
        rb_mode     = rbm;
        job_active  = 1'b1;
        cfg_load_w  = lw;
        cfg_num_act = CW'(n);
        cfg_start   = 1'b1;
        start_cyc   = cyc;
        @(posedge clk);
        #2;
        cfg_start   = 1'b0;
        cfg_load_w  = 1'($urandom);
        cfg_num_act = CW'($urandom_range(1, 9));
        @(posedge clk);
        #2;
        cfg_start = 1'b1;   // while busy: must not disturb the running job
        @(posedge clk);
        #2;
        cfg_start = 1'b0;
    endtask

    task automatic finish_job();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
        check("done_timeout", done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check("done_once", done_cnt, 1);
        check("latch_count", latch_cnt, job_lw ? 1 : 0);
        check("tokens_left", exp_q.size(), 0);
        check("accept_count", acc_cnt, job_total);
        check("idle_busy", busy, 0);
        if (!job_lw && job_num_act == 0) check("done_latency", done_cyc - start_cyc, 2);
        job_active = 1'b0;
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_busy"}, busy, 0);
        check({phase, "_done"}, done, 0);
        check({phase, "_s_ready"}, s_ready, 0);
        check({phase, "_m_valid"}, m_valid, 0);
        check({phase, "_m_shift"}, m_weight_shift, 0);
        check({phase, "_latch"}, weight_latch_en, 0);
        check({phase, "_m_data"}, m_data, 0);
    endtask

    initial begin
        bit found;
        rst_n       = 1'b0;
        cfg_start   = 1'b0;
        cfg_load_w  = 1'b0;
        cfg_num_act = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        row_busy    = 1'b0;
        m_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        start_job(1, 3, 0, 0, 1);   // basic load + stream
        finish_job();
        start_job(1, 6, 1, 0, 1);   // 1010 downstream stall
        finish_job();
        start_job(1, 3, 0, 1, 1);   // row_busy delays the latch
        finish_job();
        start_job(1, 0, 0, 0, 1);   // weights only
        finish_job();
        start_job(0, 2, 0, 0, 1);   // reuse weights
        finish_job();
        start_job(0, 0, 2, 0, 1);   // empty job
        finish_job();

        // abort mid-stream with a token sitting in the output stage
        start_job(1, 20, 2, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (exp_q.size() <= 18 && m_valid) found = 1'b1;
        end
        check("abort_reached_stream", found, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        job_active = 1'b0;
        busy_hold  = 0;
        src_q.delete();
        exp_q.delete();
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        start_job(1, 4, 0, 0, 1);
        finish_job();

        for (int j = 0; j < 8; j++) begin
            start_job(1'($urandom_range(0, 1)), $urandom_range(0, 10),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
            finish_job();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
